// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared constants and types for the pipeline front end.
//               NOP_INSTR        - canonical bubble instruction (addi x0,x0,0)
//               DEFAULT_RESET_PC - default first fetch address after reset
//               fetch_state_t    - fetch FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,   // request outstanding, accepting a response
        HOLD    = 2'd1,   // fetched word buffered, waiting for decode
        DISCARD = 2'd2    // in-flight response belongs to a redirected path
    } fetch_state_t;

endpackage : rv_pipe_pkg
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. flush loads a bubble and wins over
//               enable; with enable low and no flush all fields hold.
// Ports       : clk, rst_n (sync, active-low)
//               enable, flush             - load control
//               instr_in/pc_in/pcplus4_in/valid_in - next contents
//               instr/pc/pcplus4/valid    - registered contents
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import rv_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pcplus4_in,
    input  logic        valid_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            instr   <= NOP_INSTR;
            pc      <= 32'h0;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (enable) begin
            instr   <= instr_in;
            pc      <= pc_in;
            pcplus4 <= pcplus4_in;
            valid   <= valid_in;
        end
    end

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with a req/ack instruction memory
//               port, a one-word hold buffer for decode stalls, and branch
//               redirect handling (including dropping an in-flight response).
// Macro       : FETCH_PERF_EN - adds FetchWaitCnt / RedirectCnt counters.
// Ports       : clk, rst_n (sync, active-low)
//               StallF, StallD, FlushD, PCSrcE, PCTargetE - hazard/redirect
//               imem_req/imem_addr/imem_ack/imem_rdata   - memory handshake
//               InstrD, PCD, PCPlus4D, ValidD            - IF/ID contents
//               FetchBusyF - request outstanding without ack
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusyF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchWaitCnt,
    output logic [31:0] RedirectCnt
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pcf, pcf_next;
    logic [31:0]  hold_instr, hold_instr_next;
    logic [31:0]  hold_pc, hold_pc_next;
    logic [31:0]  pend_target, pend_target_next;
    logic         req_raw;
    logic         deliver;
    logic [31:0]  deliver_instr;
    logic [31:0]  deliver_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pcf         <= RESET_PC;
            hold_instr  <= 32'h0;
            hold_pc     <= 32'h0;
            pend_target <= 32'h0;
        end else begin
            state       <= state_next;
            pcf         <= pcf_next;
            hold_instr  <= hold_instr_next;
            hold_pc     <= hold_pc_next;
            pend_target <= pend_target_next;
        end
    end

    // StallF is folded into the stall test so the fetch path never advances
    // PCF while the front end is stalled, even if decode is free.
    always_comb begin
        state_next       = state;
        pcf_next         = pcf;
        hold_instr_next  = hold_instr;
        hold_pc_next     = hold_pc;
        pend_target_next = pend_target;
        req_raw          = 1'b0;
        deliver          = 1'b0;
        deliver_instr    = hold_instr;
        deliver_pc       = hold_pc;
        case (state)
            FETCH: begin
                req_raw = 1'b1;
                if (imem_ack) begin
                    if (PCSrcE) begin
                        pcf_next = PCTargetE;
                    end else if (StallD || StallF) begin
                        hold_instr_next = imem_rdata;
                        hold_pc_next    = pcf;
                        state_next      = HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        deliver_pc    = pcf;
                        pcf_next      = pcf + 32'd4;
                    end
                end else if (PCSrcE) begin
                    // Memory still owns the request: keep req/addr stable
                    // and remember where to go once it completes.
                    pend_target_next = PCTargetE;
                    state_next       = DISCARD;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_next   = PCTargetE;
                    state_next = FETCH;
                end else if (!StallD && !StallF) begin
                    deliver    = 1'b1;
                    pcf_next   = pcf + 32'd4;
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                req_raw = 1'b1;
                if (PCSrcE) begin
                    pend_target_next = PCTargetE;
                end
                if (imem_ack) begin
                    pcf_next   = PCSrcE ? PCTargetE : pend_target;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Gate with rst_n so no request is visible while reset is asserted.
    assign imem_req   = req_raw & rst_n;
    assign imem_addr  = pcf;
    assign FetchBusyF = imem_req & ~imem_ack;

    ifid_reg u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (~StallD),
        .flush      (FlushD),
        .instr_in   (deliver ? deliver_instr : NOP_INSTR),
        .pc_in      (deliver ? deliver_pc : 32'h0),
        .pcplus4_in (deliver ? (deliver_pc + 32'd4) : 32'h0),
        .valid_in   (deliver),
        .instr      (InstrD),
        .pc         (PCD),
        .pcplus4    (PCPlus4D),
        .valid      (ValidD)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FetchWaitCnt <= 32'h0;
            RedirectCnt  <= 32'h0;
        end else begin
            if (imem_req && !imem_ack && (FetchWaitCnt != 32'hFFFF_FFFF)) begin
                FetchWaitCnt <= FetchWaitCnt + 32'd1;
            end
            if (PCSrcE && (RedirectCnt != 32'hFFFF_FFFF)) begin
                RedirectCnt <= RedirectCnt + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. A second
//               instance with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst_n, StallF, StallD, FlushD, PCSrcE, imem_ack;
    logic [31:0] PCTargetE;
    logic        imem_req, ValidD, FetchBusyF;
    logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

    logic        rst_n2, ack2, zero;
    logic        req2, valid2, busy2;
    logic [31:0] addr2, rdata2, instr2, pcd2, pcp4d2;

    integer tests = 0;
    integer fails = 0;

`ifdef FETCH_PERF_EN
    logic [31:0] FetchWaitCnt, RedirectCnt, wait2, redir2;
`endif

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ KEY;
    assign rdata2     = addr2 ^ KEY;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
`ifdef FETCH_PERF_EN
        , .FetchWaitCnt(FetchWaitCnt), .RedirectCnt(RedirectCnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n2), .StallF(zero), .StallD(zero),
        .FlushD(zero), .PCSrcE(zero), .PCTargetE(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .InstrD(instr2), .PCD(pcd2),
        .PCPlus4D(pcp4d2), .ValidD(valid2), .FetchBusyF(busy2)
`ifdef FETCH_PERF_EN
        , .FetchWaitCnt(wait2), .RedirectCnt(redir2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        rst_n2 = 1'b0; ack2 = 1'b0;
        step();
        rst_n2 = 1'b1; ack2 = 1'b1; #1;
        tests++; if (addr2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first_addr got=%h exp=%h", addr2, 32'hFFFF_FFFC); end
        step();
        tests++; if (addr2 !== 32'h0) begin fails++; $display("FAIL wrap_second_addr got=%h exp=%h", addr2, 32'h0); end
        tests++; if (pcd2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pcd got=%h exp=%h", pcd2, 32'hFFFF_FFFC); end
        tests++; if (pcp4d2 !== 32'h0) begin fails++; $display("FAIL wrap_pcplus4 got=%h exp=%h", pcp4d2, 32'h0); end
        ack2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; imem_ack = 1'b0;
        step(); step();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        tests++; if (FetchBusyF !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", FetchBusyF); end
        tests++; if (ValidD !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", ValidD); end
        tests++; if (InstrD !== NOP) begin fails++; $display("FAIL reset_instr got=%h exp=%h", InstrD, NOP); end
        tests++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h/%h exp=0/0", PCD, PCPlus4D); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        rst_n = 1'b1; imem_ack = 1'b1; #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL zw_first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
        tests++; if (FetchBusyF !== 1'b0) begin fails++; $display("FAIL zw_busy got=%b exp=0", FetchBusyF); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (PCD !== 32'(4*i) || ValidD !== 1'b1 || InstrD !== (32'(4*i) ^ KEY) || PCPlus4D !== 32'(4*i+4)) begin
                fails++; $display("FAIL zw_ifid[%0d] got pc=%h v=%b i=%h p4=%h exp pc=%h v=1", i, PCD, ValidD, InstrD, PCPlus4D, 32'(4*i));
            end
            tests++; if (imem_addr !== 32'(4*i+4)) begin fails++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(4*i+4)); end
        end
    endtask

    task automatic test_wait_states();
        imem_ack = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || FetchBusyF !== 1'b1) begin fails++; $display("FAIL ws_hold[%0d] got req=%b addr=%h busy=%b exp 1/00000010/1", i, imem_req, imem_addr, FetchBusyF); end
            step();
            tests++; if (InstrD !== NOP || ValidD !== 1'b0) begin fails++; $display("FAIL ws_bubble[%0d] got i=%h v=%b exp=%h/0", i, InstrD, ValidD, NOP); end
        end
        imem_ack = 1'b1; #1;
        tests++; if (FetchBusyF !== 1'b0) begin fails++; $display("FAIL ws_busy_ack got=%b exp=0", FetchBusyF); end
        step();
        tests++; if (PCD !== 32'h10 || ValidD !== 1'b1 || InstrD !== (32'h10 ^ KEY)) begin fails++; $display("FAIL ws_deliver got pc=%h v=%b i=%h exp pc=00000010 v=1", PCD, ValidD, InstrD); end
        tests++; if (imem_addr !== 32'h14) begin fails++; $display("FAIL ws_next_addr got=%h exp=00000014", imem_addr); end
    endtask

    task automatic test_hold();
        step(); step(); step();
        tests++; if (imem_addr !== 32'h20 || PCD !== 32'h1C) begin fails++; $display("FAIL hold_setup got addr=%h pcd=%h exp 20/1c", imem_addr, PCD); end
        StallD = 1'b1;
        step();
        imem_ack = 1'b0; #1;
        tests++; if (imem_req !== 1'b0 || FetchBusyF !== 1'b0) begin fails++; $display("FAIL hold_req got=%b busy=%b exp=0/0", imem_req, FetchBusyF); end
        tests++; if (PCD !== 32'h1C || ValidD !== 1'b1 || imem_addr !== 32'h20) begin fails++; $display("FAIL hold_ifid1 got pcd=%h v=%b addr=%h exp 1c/1/20", PCD, ValidD, imem_addr); end
        step();
        tests++; if (PCD !== 32'h1C || imem_req !== 1'b0) begin fails++; $display("FAIL hold_ifid2 got pcd=%h req=%b exp 1c/0", PCD, imem_req); end
        StallD = 1'b0; imem_ack = 1'b1;
        step();
        tests++; if (PCD !== 32'h20 || ValidD !== 1'b1 || InstrD !== (32'h20 ^ KEY)) begin fails++; $display("FAIL hold_release got pcd=%h v=%b i=%h exp pcd=00000020 v=1", PCD, ValidD, InstrD); end
        tests++; if (imem_addr !== 32'h24 || imem_req !== 1'b1) begin fails++; $display("FAIL hold_next_addr got=%h req=%b exp 24/1", imem_addr, imem_req); end
    endtask

    task automatic test_redirect();
        step(); step(); step();
        imem_ack = 1'b0;
        step();
        tests++; if (imem_addr !== 32'h30 || ValidD !== 1'b0) begin fails++; $display("FAIL rd_setup got addr=%h v=%b exp 30/0", imem_addr, ValidD); end
        PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1;
        step();
        PCSrcE = 1'b0; FlushD = 1'b0; #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin fails++; $display("FAIL rd_discard_hold got req=%b addr=%h exp 1/30", imem_req, imem_addr); end
        tests++; if (ValidD !== 1'b0 || InstrD !== NOP) begin fails++; $display("FAIL rd_flush_bubble got v=%b i=%h exp 0/%h", ValidD, InstrD, NOP); end
        imem_ack = 1'b1;
        step();
        tests++; if (ValidD !== 1'b0 || InstrD !== NOP) begin fails++; $display("FAIL rd_drop got v=%b i=%h exp 0/%h", ValidD, InstrD, NOP); end
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL rd_target_addr got=%h exp=00000100", imem_addr); end
        step();
        tests++; if (PCD !== 32'h100 || ValidD !== 1'b1 || InstrD !== (32'h100 ^ KEY)) begin fails++; $display("FAIL rd_target_fetch got pcd=%h v=%b i=%h exp pcd=00000100 v=1", PCD, ValidD, InstrD); end
`ifdef FETCH_PERF_EN
        tests++; if (RedirectCnt !== 32'd1) begin fails++; $display("FAIL perf_redirect got=%0d exp=1", RedirectCnt); end
        tests++; if (FetchWaitCnt !== 32'd5) begin fails++; $display("FAIL perf_wait got=%0d exp=5", FetchWaitCnt); end
`endif
    endtask

    task automatic test_flush_over_stall();
        StallD = 1'b1; FlushD = 1'b1; imem_ack = 1'b1;
        step();
        FlushD = 1'b0; imem_ack = 1'b0; #1;
        tests++; if (ValidD !== 1'b0 || InstrD !== NOP) begin fails++; $display("FAIL fs_bubble got v=%b i=%h exp 0/%h", ValidD, InstrD, NOP); end
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h104) begin fails++; $display("FAIL fs_hold_state got req=%b addr=%h exp 0/104", imem_req, imem_addr); end
        step();
    endtask

    task automatic test_reset_mid_hold();
        rst_n = 1'b0;
        step();
        tests++; if (ValidD !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL rst_hold got v=%b addr=%h exp 0/0", ValidD, imem_addr); end
        tests++; if (imem_req !== 1'b0 || FetchBusyF !== 1'b0) begin fails++; $display("FAIL rst_hold_req got req=%b busy=%b exp 0/0", imem_req, FetchBusyF); end
`ifdef FETCH_PERF_EN
        tests++; if (FetchWaitCnt !== 32'd0 || RedirectCnt !== 32'd0) begin fails++; $display("FAIL rst_perf got=%0d/%0d exp 0/0", FetchWaitCnt, RedirectCnt); end
`endif
        rst_n = 1'b1; StallD = 1'b0; imem_ack = 1'b1; #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL rst_first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
        step();
        tests++; if (PCD !== 32'h0 || ValidD !== 1'b1 || imem_addr !== 32'h4) begin fails++; $display("FAIL rst_first_fetch got pcd=%h v=%b addr=%h exp 0/1/4", PCD, ValidD, imem_addr); end
    endtask

    initial begin
        zero = 1'b0; rst_n2 = 1'b0; ack2 = 1'b0;
        test_reset();
        test_wrap();
        test_zero_wait();
        test_wait_states();
        test_hold();
        test_redirect();
        test_flush_over_stall();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports StallF, StallD, FlushD, PCSrcE  in  1 each  hazard/branch control from execute and hazard unit.
REQ-005 SHALL have port PCTargetE  in  32  redirect target, sampled when PCSrcE=1.
REQ-006 SHALL have ports imem_req out 1, imem_addr out 32, imem_ack in 1, imem_rdata in 32  instruction memory handshake.
REQ-007 SHALL have ports InstrD out 32, PCD out 32, PCPlus4D out 32, ValidD out 1  IF/ID register contents.
REQ-008 SHALL have port FetchBusyF  out  1  high while a request is outstanding without ack.

Function
REQ-009 SHALL keep PCF internally, drive imem_addr=PCF, and hold imem_req and imem_addr stable from assertion until the cycle imem_ack=1.
REQ-010 SHALL accept imem_ack in the same cycle as imem_req, giving zero-wait-state fetch.
REQ-011 SHALL implement FSM states FETCH (req=1), HOLD (req=0, fetched word buffered), and DISCARD (req=1, in-flight response to be dropped).
REQ-012 FETCH with ack=1, StallF=0, StallD=0: SHALL load imem_rdata, PCF and PCF+4 into IF/ID with ValidD=1, set PCF+=4, and remain in FETCH.
REQ-013 FETCH with ack=1 and StallD=1: SHALL capture the word and PC into a hold buffer and go to HOLD; PCF unchanged.
REQ-014 HOLD with StallD=0: SHALL move the buffer into IF/ID with ValidD=1, set PCF+=4, and go to FETCH.
REQ-015 FETCH with ack=0 and StallD=0: SHALL load a bubble into IF/ID (ValidD=0, InstrD=NOP 32'h0000_0013).
REQ-016 StallD=1 without FlushD: IF/ID SHALL hold all fields.
REQ-017 FlushD=1: IF/ID SHALL load the bubble, overriding StallD and any fetched word.
REQ-018 PCSrcE=1 in HOLD, or in FETCH with ack=1: SHALL set PCF=PCTargetE, drop the fetched/buffered word, and go to FETCH; this overrides StallF.
REQ-019 PCSrcE=1 in FETCH with ack=0: SHALL latch PCTargetE as the pending target and go to DISCARD, keeping req and addr unchanged.
REQ-020 DISCARD with ack=1: SHALL drop rdata, set PCF=pending target, and go to FETCH; a further PCSrcE in DISCARD SHALL overwrite the pending target.
REQ-021 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-022 StallF=1 with StallD=0 SHALL behave as StallD=1 for the fetch path (no PCF advance); IF/ID follows REQ-015/016/017.

Reset
REQ-023 rst_n=0 at a clock edge SHALL set state=FETCH, PCF=RESET_PC, InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0, and clear the hold buffer and pending target.
REQ-024 Reset while a request is outstanding SHALL take effect immediately; the first request after reset SHALL issue at RESET_PC in the first cycle with rst_n=1, and a late ack for the old request is the memory's responsibility to suppress.
REQ-025 During reset imem_req SHALL be 0 and FetchBusyF SHALL be 0.

Configuration
REQ-026 With FETCH_PERF_EN defined: SHALL add outputs FetchWaitCnt[31:0] (cycles with req=1 and ack=0) and RedirectCnt[31:0] (PCSrcE=1 cycles). Both saturate at all-ones and reset to 0.
REQ-027 Without FETCH_PERF_EN: SHALL omit these ports and counters, with no other behavioural change.

Structure
REQ-028 Package rv_pipe_pkg SHALL hold the NOP constant, the default RESET_PC, and the fetch_state_t enum {FETCH, HOLD, DISCARD}.
REQ-029 IF/ID register SHALL be sub-module ifid_reg (inputs: enable, flush; fields: instr, pc, pcplus4, valid); FSM and PCF stay in fetch_stage.

Verification
REQ-030 Reset then zero-wait memory, no stalls: addresses 0,4,8 in consecutive cycles; PCD=0,4,8 with ValidD=1.
REQ-031 ack delayed 3 cycles at PC=0x10: req/addr stable for 3 cycles, FetchBusyF=1, three bubbles (InstrD=0x00000013, ValidD=0), then PCD=0x10.
REQ-032 StallD=1 for 2 cycles while ack arrives at PC=0x20: state goes to HOLD, req=0, IF/ID holds; after release PCD=0x20 and next addr=0x24.
REQ-033 PCSrcE=1, PCTargetE=0x100 while waiting on PC=0x30: rdata for 0x30 dropped; next addr=0x100; FlushD bubble in D.
REQ-034 RESET_PC=0xFFFF_FFFC: second fetch addr=0x0.
REQ-035 rst_n=0 mid-HOLD: next cycle ValidD=0, imem_addr=RESET_PC; with FETCH_PERF_EN defined both counters read 0.
